dmem_bank: RTL
==============

DMEM_BANK -- requirements
Module: dmem_bank

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, meaning the data word width; legal values are 32 or 64.
REQ-002 SHALL derive parameter BE_W as DATA_W/8, meaning the number of byte enables.
REQ-003 SHALL provide parameter DEPTH, default 1024, meaning the number of words; it SHALL be a power of 2.
REQ-004 SHALL provide parameter BASE_ADDR, default 32'h0001_0000, meaning the byte address of word 0.
REQ-005 SHALL provide parameter RD_LAT, default 1, meaning read pipeline stages; legal range 1..3.
REQ-006 SHALL provide parameter FIFO_DEPTH, default 4, meaning response FIFO entries; it SHALL be >= RD_LAT+1.
REQ-007 SHALL provide parameter INIT_FILE, default "", meaning a hex image loaded at time 0 when non-empty.
REQ-008 Clk  in  1  -- the single clock; all state updates on its rising edge.
REQ-009 Rst  in  1  -- asynchronous, active-low reset.
REQ-010 ReqValid  in  1  -- a request is present.
REQ-011 ReqReady  out  1  -- the request is accepted when ReqValid && ReqReady at a rising edge.
REQ-012 ReqWrEn  in  1  -- 1 = write, 0 = read.
REQ-013 ReqAddr  in  32  -- byte address.
REQ-014 ReqData  in  DATA_W  -- write data.
REQ-015 ReqByteEn  in  BE_W  -- per-byte write enable; ignored on reads.
REQ-016 RspValid  out  1  -- head of the response FIFO is valid.
REQ-017 RspReady  in  1  -- the response is popped when RspValid && RspReady.
REQ-018 RspData  out  DATA_W  -- read data.
REQ-019 RspErr  out  1  -- the read address was illegal.
REQ-020 RdCnt  out  32  -- accepted reads.
REQ-021 WrCnt  out  32  -- accepted legal writes.
REQ-022 ErrCnt  out  16  -- illegal requests.

Function
REQ-023 An address SHALL be illegal when ReqAddr < BASE_ADDR, when ReqAddr >= BASE_ADDR + DEPTH*BE_W, or when ReqAddr[log2(BE_W)-1:0] != 0.
REQ-024 A legal address SHALL index word (ReqAddr-BASE_ADDR)>>log2(BE_W).
REQ-025 An accepted legal write SHALL update only the bytes whose ReqByteEn bit is 1, at the accepting edge; it SHALL produce no response and SHALL increment WrCnt.
REQ-026 An accepted illegal write SHALL leave memory unchanged, SHALL produce no response and SHALL increment ErrCnt.
REQ-027 An accepted read SHALL push exactly one FIFO entry, with RspValid high RD_LAT cycles after the accept cycle when the FIFO was empty (RD_LAT=1: the next cycle); it SHALL increment RdCnt.
REQ-028 An accepted illegal read SHALL return RspErr=1 with RspData=0 and SHALL increment ErrCnt (in addition to RdCnt).
REQ-029 A read SHALL observe every write accepted in an earlier cycle, including the immediately preceding cycle.
REQ-030 Responses SHALL be returned in request order.
REQ-031 The FIFO SHALL be first-word-fall-through; RspData/RspErr SHALL be stable while RspValid && !RspReady.
REQ-032 ReqReady SHALL equal (reads in flight + FIFO occupancy) < FIFO_DEPTH, computed from registered state only, with no combinational path from ReqValid or RspReady.
REQ-033 A write SHALL be accepted under the same ReqReady rule, so that ordering is preserved.
REQ-034 A push and a pop in the same cycle SHALL leave the occupancy unchanged; a pop on empty SHALL be impossible by construction.
REQ-035 All counters SHALL saturate at their maximum value and SHALL not wrap.
REQ-036 FIFO pointers SHALL wrap modulo FIFO_DEPTH without losing or duplicating entries.

Reset
REQ-037 Rst=0 SHALL immediately clear the read pipeline, the FIFO pointers, RspValid, RspErr, RspData (to 0) and all counters; ReqReady SHALL be 1.
REQ-038 Reads in flight when reset is asserted SHALL be discarded and never returned.
REQ-039 Memory contents SHALL NOT be affected by reset.

Verification
REQ-040 Write 32'hDEADBEEF to BASE, ByteEn=4'b0101, over a prior 0, then read BASE -> RspData=32'h00AD00EF, RspErr=0, WrCnt=1, RdCnt=1.
REQ-041 Write then read the same address in back-to-back cycles, RD_LAT=1 -> the read returns the new data one cycle after acceptance.
REQ-042 Read BASE+2 (misaligned) and read BASE+DEPTH*4 (out of range) -> two responses with RspErr=1, RspData=0, ErrCnt=2.
REQ-043 RspReady=0 while issuing 6 reads, FIFO_DEPTH=4 -> ReqReady drops after 4 acceptances; raising RspReady returns all reads in order.
REQ-044 Assert Rst mid-stream with 2 reads in flight, RD_LAT=3 -> RspValid=0 immediately, no stale response afterwards, and memory contents are retained.
REQ-045 Random traffic with RspReady toggling for 10k cycles, RD_LAT in {1,2,3} -> every response matches a scoreboard model.

Source files
------------

// File: rtl/dmem_bank.sv
// dmem_bank: single-port byte-maskable data memory with a request/response
// handshake. Reads travel through an RD_LAT-deep pipeline into a FWFT response
// FIFO; ReqReady is derived from registered state so the bank never overflows.
module dmem_bank #(
  parameter int          DATA_W     = 32,
  parameter int          BE_W       = DATA_W / 8,
  parameter int          DEPTH      = 1024,
  parameter logic [31:0] BASE_ADDR  = 32'h0001_0000,
  parameter int          RD_LAT     = 1,
  parameter int          FIFO_DEPTH = 4,
  parameter string       INIT_FILE  = ""
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic              ReqWrEn,
  input  logic [31:0]       ReqAddr,
  input  logic [DATA_W-1:0] ReqData,
  input  logic [BE_W-1:0]   ReqByteEn,
  output logic              RspValid,
  input  logic              RspReady,
  output logic [DATA_W-1:0] RspData,
  output logic              RspErr,
  output logic [31:0]       RdCnt,
  output logic [31:0]       WrCnt,
  output logic [15:0]       ErrCnt
);

  localparam int OB = $clog2(BE_W);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [32:0] SPAN = 33'(DEPTH) * 33'(BE_W);
  localparam logic [CW:0] FD_C = (CW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic              err;
    logic [DATA_W-1:0] data;
  } rsp_t;

  logic              accept, rdAcc, wrAcc, legal;
  logic [31:0]       offset;
  logic [AW-1:0]     wordIdx;
  logic [DATA_W-1:0] mem [DEPTH];
  rsp_t              rdRsp, pushRsp;
  logic              pushVld, pop;
  logic [CW-1:0]     inFlight, count;
  logic [PW-1:0]     wrPtr, rdPtr;
  rsp_t              fifoMem [FIFO_DEPTH];

  // Offset arithmetic keeps the range check correct even if BASE+span overflows 32 bits.
  assign offset  = ReqAddr - BASE_ADDR;
  assign legal   = (ReqAddr >= BASE_ADDR) && ({1'b0, offset} < SPAN) &&
                   (ReqAddr[OB-1:0] == '0);
  assign wordIdx = offset[OB +: AW];

  assign accept = ReqValid && ReqReady;
  assign rdAcc  = accept && !ReqWrEn;
  assign wrAcc  = accept && ReqWrEn && legal;

  // Read is sampled at the accepting edge, so any write from an earlier cycle is visible.
  assign rdRsp.err  = !legal;
  assign rdRsp.data = legal ? mem[wordIdx] : '0;

  // Byte-masked write; memory deliberately has no reset.
  always_ff @(posedge Clk) begin
    if (wrAcc)
      for (int b = 0; b < BE_W; b++)
        if (ReqByteEn[b]) mem[wordIdx][b*8 +: 8] <= ReqData[b*8 +: 8];
  end

  // RD_LAT=1 pushes straight into the FIFO at the accept edge; deeper
  // latencies add RD_LAT-1 registered stages in front of it.
  if (RD_LAT == 1) begin : gLat1
    assign pushVld  = rdAcc;
    assign pushRsp  = rdRsp;
    assign inFlight = '0;
  end else begin : gLatN
    logic [RD_LAT-1:1] vldPipe;
    rsp_t              rspPipe [RD_LAT-1:1];

    // Read pipeline shift register; reset drops anything in flight.
    always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
        vldPipe <= '0;
        for (int i = 1; i < RD_LAT; i++) rspPipe[i] <= '0;
      end else begin
        vldPipe[1] <= rdAcc;
        rspPipe[1] <= rdRsp;
        for (int i = 2; i < RD_LAT; i++) begin
          vldPipe[i] <= vldPipe[i-1];
          rspPipe[i] <= rspPipe[i-1];
        end
      end
    end

    assign pushVld  = vldPipe[RD_LAT-1];
    assign pushRsp  = rspPipe[RD_LAT-1];
    assign inFlight = CW'($countones(vldPipe));
  end

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credit check from registered state only: every accepted read owns a FIFO slot.
  assign ReqReady = ({1'b0, inFlight} + {1'b0, count}) < FD_C;
  assign RspValid = (count != '0);
  assign pop      = RspValid && RspReady;
  assign RspData  = RspValid ? fifoMem[rdPtr].data : '0;
  assign RspErr   = RspValid ? fifoMem[rdPtr].err  : 1'b0;

  // FIFO pointers and occupancy; simultaneous push/pop leaves count unchanged.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (pushVld) wrPtr <= nextPtr(wrPtr);
      if (pop)     rdPtr <= nextPtr(rdPtr);
      case ({pushVld, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; contents are masked by RspValid so no reset is needed.
  always_ff @(posedge Clk) begin
    if (pushVld) fifoMem[wrPtr] <= pushRsp;
  end

  // Saturating activity counters.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      RdCnt  <= '0;
      WrCnt  <= '0;
      ErrCnt <= '0;
    end else begin
      if (rdAcc && (RdCnt != '1))             RdCnt  <= RdCnt + 1'b1;
      if (wrAcc && (WrCnt != '1))             WrCnt  <= WrCnt + 1'b1;
      if (accept && !legal && (ErrCnt != '1)) ErrCnt <= ErrCnt + 1'b1;
    end
  end

endmodule
